// File: rtl/mem_unit.sv
// rtl/mem_unit.sv - data-memory unit: MAR, MDR, RAM array and wait-state access FSM
//
// Purpose:
//   Holds the memory address register (MAR), the memory data register (MDR)
//   and a synchronous RAM. Each memEN access is answered with MFC after
//   WAIT_CYCLES clocks. The MDR and MAR connect to the internal bus.
//
// Ports:
//   clk         in   rising-edge system clock
//   rst         in   asynchronous active-low reset
//   bus_in      in   internal bus value (address or store data)
//   marIn       in   load MAR from bus_in[ADDR_W-1:0]
//   mdrWriteEN  in   load MDR from bus_in
//   mdrReadEN   in   load MDR from the RAM read latch (wins over mdrWriteEN)
//   mdrOut      in   drive MDR onto bus_out
//   memEN       in   access request, held until MFC is seen
//   RW          in   1 = read, 0 = write, sampled when the access is accepted
//   bus_out     out  MDR when mdrOut = 1, else zero
//   MFC         out  memory function complete (registered)
//   busy        out  high while an access is in BUSY or DONE
module mem_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 2 ** ADDR_W,
  parameter int WAIT_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] bus_in,
  input  logic              marIn,
  input  logic              mdrWriteEN,
  input  logic              mdrReadEN,
  input  logic              mdrOut,
  input  logic              memEN,
  input  logic              RW,
  output logic [DATA_W-1:0] bus_out,
  output logic              MFC,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // The counter is loaded with WAIT_CYCLES-1 at acceptance so that DONE is
  // entered exactly WAIT_CYCLES edges after the acceptance edge.
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_t              state;
  state_t              next_state;
  logic [ADDR_W-1:0]   mar;
  logic [DATA_W-1:0]   mdr;
  logic [DATA_W-1:0]   rd_latch;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   a_addr;
  logic                a_rw;
  logic [DATA_W-1:0]   a_wdata;
  logic                mfc_q;
  logic                accept;
  logic                complete;

  logic [DATA_W-1:0]   ram [DEPTH];

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (memEN) next_state = BUSY;
      end
      BUSY: begin
        if (!memEN)          next_state = IDLE;
        else if (cnt == 4'd0) next_state = DONE;
      end
      DONE: begin
        if (!memEN) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept   = (state == IDLE) && memEN;
  // Completion edge of an access that was not aborted
  assign complete = (state == BUSY) && memEN && (cnt == 4'd0);

  // Datapath registers, wait counter and access fields latched at acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mar      <= '0;
      mdr      <= '0;
      rd_latch <= '0;
      cnt      <= '0;
      a_addr   <= '0;
      a_rw     <= 1'b0;
      a_wdata  <= '0;
      mfc_q    <= 1'b0;
    end else begin
      if (marIn) mar <= bus_in[ADDR_W-1:0];

      if (mdrReadEN)       mdr <= rd_latch;
      else if (mdrWriteEN) mdr <= bus_in;

      if (accept) begin
        a_addr  <= mar;
        a_rw    <= RW;
        a_wdata <= mdr;
        cnt     <= CNT_INIT;
      end else if ((state == BUSY) && memEN && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end

      if (complete && a_rw) rd_latch <= ram[a_addr];

      // MFC is registered alongside the state so it is high exactly in DONE
      mfc_q <= (next_state == DONE);
    end
  end

  // RAM contents are not reset; reset forces IDLE so no write can complete.
  always_ff @(posedge clk) begin
    if (complete && !a_rw) ram[a_addr] <= a_wdata;
  end

  assign bus_out = mdrOut ? mdr : '0;
  assign MFC     = mfc_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_unit.sv
// tb/tb_mem_unit.sv - directed self-checking bench for mem_unit
module tb_mem_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bus_in = '0;
  logic        marIn = 1'b0;
  logic        mdrWriteEN = 1'b0;
  logic        mdrReadEN = 1'b0;
  logic        mdrOut = 1'b0;
  logic        RW = 1'b0;
  logic [2:0]  memen = '0;
  logic [2:0]  mfc;
  logic [2:0]  busy;
  logic [15:0] bout [3];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_unit #(.WAIT_CYCLES(3)) u0 (
    .clk(clk), .rst(rst), .bus_in(bus_in), .marIn(marIn), .mdrWriteEN(mdrWriteEN),
    .mdrReadEN(mdrReadEN), .mdrOut(mdrOut), .memEN(memen[0]), .RW(RW),
    .bus_out(bout[0]), .MFC(mfc[0]), .busy(busy[0])
  );

  mem_unit #(.WAIT_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .bus_in(bus_in), .marIn(marIn), .mdrWriteEN(mdrWriteEN),
    .mdrReadEN(mdrReadEN), .mdrOut(mdrOut), .memEN(memen[1]), .RW(RW),
    .bus_out(bout[1]), .MFC(mfc[1]), .busy(busy[1])
  );

  mem_unit #(.WAIT_CYCLES(15)) u2 (
    .clk(clk), .rst(rst), .bus_in(bus_in), .marIn(marIn), .mdrWriteEN(mdrWriteEN),
    .mdrReadEN(mdrReadEN), .mdrOut(mdrOut), .memEN(memen[2]), .RW(RW),
    .bus_out(bout[2]), .MFC(mfc[2]), .busy(busy[2])
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mar(input logic [15:0] addr);
    bus_in = addr;
    marIn  = 1'b1;
    tick();
    marIn  = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] data);
    bus_in     = data;
    mdrWriteEN = 1'b1;
    tick();
    mdrWriteEN = 1'b0;
  endtask

  // Raise memEN and take the acceptance edge (E0).
  task automatic start_acc(input int idx, input logic rw);
    RW         = rw;
    memen[idx] = 1'b1;
    tick();
  endtask

  // Wait for MFC (bounded), check latency, optionally hold memEN through DONE,
  // then drop memEN (pulsing mdrReadEN for reads) and check MFC falls.
  task automatic finish_acc(input int idx, input int w_exp, input int already,
                            input int hold, input logic rd, input string tag);
    int n;
    n = already;
    while (!mfc[idx] && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, w_exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_mfc_hold"}, {31'd0, mfc[idx]}, 32'd1);
      check({tag, "_busy_hold"}, {31'd0, busy[idx]}, 32'd1);
    end
    memen[idx] = 1'b0;
    if (rd) mdrReadEN = 1'b1;
    tick();
    mdrReadEN = 1'b0;
    check({tag, "_mfc_fall"}, {31'd0, mfc[idx]}, 32'd0);
  endtask

  task automatic check_bus(input int idx, input logic [15:0] exp, input string tag);
    mdrOut = 1'b1;
    #1;
    check(tag, {16'd0, bout[idx]}, {16'd0, exp});
    mdrOut = 1'b0;
    #1;
  endtask

  task automatic do_write(input int idx, input logic [7:0] addr, input logic [15:0] data,
                          input int w, input string tag);
    load_mar({8'd0, addr});
    load_mdr(data);
    start_acc(idx, 1'b0);
    finish_acc(idx, w, 0, 0, 1'b0, tag);
  endtask

  task automatic do_read(input int idx, input logic [7:0] addr, input logic [15:0] exp,
                         input int w, input string tag);
    load_mar({8'd0, addr});
    start_acc(idx, 1'b1);
    finish_acc(idx, w, 0, 0, 1'b1, tag);
    check_bus(idx, exp, {tag, "_data"});
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_mfc", {31'd0, mfc[0]}, 32'd0);
    check("rst_busy", {31'd0, busy[0]}, 32'd0);
    check_bus(0, 16'h0000, "rst_mdr");
    rst = 1'b1;
    tick();

    // Preload known contents
    do_write(0, 8'h00, 16'hAAAA, 3, "pre00");
    do_write(0, 8'h10, 16'h5555, 3, "pre10");
    do_write(0, 8'h05, 16'h0505, 3, "pre05");
    do_write(0, 8'h07, 16'h0707, 3, "pre07");
    do_write(0, 8'h08, 16'h0808, 3, "pre08");

    // 1. Reset in the middle of a write to 0x10
    load_mar(16'h0010);
    load_mdr(16'h1111);
    start_acc(0, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_mfc", {31'd0, mfc[0]}, 32'd0);
    check("midrst_busy", {31'd0, busy[0]}, 32'd0);
    mdrOut = 1'b1;
    #1;
    check("midrst_bus", {16'd0, bout[0]}, 32'd0);
    mdrOut   = 1'b0;
    memen[0] = 1'b0;
    rst      = 1'b1;
    tick();
    // MAR was cleared, so a read without loading MAR targets address 0
    start_acc(0, 1'b1);
    finish_acc(0, 3, 0, 0, 1'b1, "mar_zero");
    check_bus(0, 16'hAAAA, "mar_zero_data");
    do_read(0, 8'h10, 16'h5555, 3, "rd10_after_rst");

    // 2. Store 0xBEEF to 0x42, memEN held two extra cycles in DONE
    load_mar(16'h0042);
    load_mdr(16'hBEEF);
    start_acc(0, 1'b0);
    check("st_busy_e0", {31'd0, busy[0]}, 32'd1);
    finish_acc(0, 3, 0, 2, 1'b0, "store");

    // 3. Load 0x42 back (MAR still 0x42)
    load_mdr(16'h0000);
    start_acc(0, 1'b1);
    finish_acc(0, 3, 0, 0, 1'b1, "load");
    check_bus(0, 16'hBEEF, "load_data");
    #1;
    check("load_mdrout_off", {16'd0, bout[0]}, 32'd0);

    // 4. Abort a write of 0x1234 to 0x05 after one BUSY cycle
    load_mar(16'h0005);
    load_mdr(16'h1234);
    start_acc(0, 1'b0);
    tick();
    memen[0] = 1'b0;
    tick();
    check("abort_busy", {31'd0, busy[0]}, 32'd0);
    check("abort_mfc", {31'd0, mfc[0]}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_mfc_late", {31'd0, mfc[0]}, 32'd0);
    end
    do_read(0, 8'h05, 16'h0505, 3, "abort_rd05");

    // 5. Read of 0x07 with MAR and RW changed during BUSY
    load_mar(16'h0007);
    start_acc(0, 1'b1);
    RW     = 1'b0;
    bus_in = 16'h0008;
    marIn  = 1'b1;
    tick();
    marIn  = 1'b0;
    finish_acc(0, 3, 1, 0, 1'b1, "latch");
    check_bus(0, 16'h0707, "latch_data");
    do_read(0, 8'h08, 16'h0808, 3, "latch_rd08");

    // 6a. WAIT_CYCLES = 1: write, one idle cycle, back-to-back read
    do_write(1, 8'h20, 16'hC001, 1, "w1_wr");
    start_acc(1, 1'b1);
    finish_acc(1, 1, 0, 3, 1'b1, "w1_rd");
    check_bus(1, 16'hC001, "w1_data");

    // 6b. WAIT_CYCLES = 15: memEN held high long after DONE
    load_mar(16'h0030);
    load_mdr(16'hF00F);
    start_acc(2, 1'b0);
    finish_acc(2, 15, 0, 20, 1'b0, "w15_wr");
    start_acc(2, 1'b1);
    finish_acc(2, 15, 0, 0, 1'b1, "w15_rd");
    check_bus(2, 16'hF00F, "w15_data");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
